// File: rtl/cmp_pkg.sv
// Shared encodings for the compare blocks: FSM state and one-hot result.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp_pkg;

  // Two-state sequencer: waiting for a request, or walking operand bits.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // One-hot compare result, shared with sibling compare blocks.
  typedef enum logic [2:0] {
    LT = 3'b001,
    GT = 3'b010,
    EQ = 3'b100
  } cmp_res_e;

endpackage

// File: rtl/bit_cmp_cell.sv
// Gate-level 1-bit magnitude comparator: lt = x<y, gt = x>y, eq = x==y.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module bit_cmp_cell (
  input  logic x,
  input  logic y,
  output logic lt,
  output logic gt,
  output logic eq
);

  logic x_n;
  logic y_n;

  not  u_not_x (x_n, x);
  not  u_not_y (y_n, y);
  and  u_and_lt (lt, x_n, y);
  and  u_and_gt (gt, x, y_n);
  xnor u_xnor_eq (eq, x, y);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial unsigned magnitude compare, MSB first, through one 1-bit cell.
// Latency: done in cycle WIDTH-p+1 (early exit at diff bit p) or WIDTH+1.
// Backpressure: start is ignored while busy; no queuing of requests.
module serial_mag_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             greater,
  output logic             equal
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  ra_q, ra_d;
  logic [WIDTH-1:0]  rb_q, rb_d;
  // Sticky record of the first differing bit; both low means no difference yet.
  logic              lt_q, lt_d;
  logic              gt_q, gt_d;
  logic              done_q, done_d;
  logic [2:0]        res_q, res_d;

  logic              bit_x;
  logic              bit_y;
  logic              cell_lt;
  logic              cell_gt;
  logic              cell_eq;
  logic              scan_exit;

  // Bit-select mux feeding the single comparator cell.
  assign bit_x = ra_q[idx_q];
  assign bit_y = rb_q[idx_q];

  bit_cmp_cell u_cell (
    .x  (bit_x),
    .y  (bit_y),
    .lt (cell_lt),
    .gt (cell_gt),
    .eq (cell_eq)
  );

  // Next-state logic: accept requests, walk idx down, latch result on exit.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    res_d     = res_q;
    done_d    = 1'b0;
    scan_exit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IDXW'(WIDTH - 1);
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Only the first differing bit decides; later bits cannot overwrite it.
        if (!(lt_q || gt_q)) begin
          lt_d = cell_lt;
          gt_d = cell_gt;
        end
        scan_exit = (EARLY_EXIT && !cell_eq) || (idx_q == '0);
        if (scan_exit) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (lt_d) begin
            res_d = LT;
          end else if (gt_d) begin
            res_d = GT;
          end else begin
            res_d = EQ;
          end
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything, including mid-scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy    = (state_q == ST_SCAN);
  assign done    = done_q;
  assign less    = (res_q == LT);
  assign greater = (res_q == GT);
  assign equal   = (res_q == EQ);

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench for serial_mag_compare_ctrl: early-exit and fixed-latency instances.
// Latency: checks done cycle against hand-computed values.
// Backpressure: checks start is ignored while busy and accepted in the done cycle.
module tb_serial_mag_compare_ctrl;

  logic       clk;
  logic       rst;

  logic       start_ee, start_fx;
  logic [7:0] a_ee, b_ee, a_fx, b_fx;
  logic       busy_ee, done_ee, less_ee, greater_ee, equal_ee;
  logic       busy_fx, done_fx, less_fx, greater_fx, equal_fx;

  int n_tests;
  int n_fail;

  serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk     (clk),
    .rst     (rst),
    .start   (start_ee),
    .a       (a_ee),
    .b       (b_ee),
    .busy    (busy_ee),
    .done    (done_ee),
    .less    (less_ee),
    .greater (greater_ee),
    .equal   (equal_ee)
  );

  serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_fx (
    .clk     (clk),
    .rst     (rst),
    .start   (start_fx),
    .a       (a_fx),
    .b       (b_fx),
    .busy    (busy_fx),
    .done    (done_fx),
    .less    (less_fx),
    .greater (greater_fx),
    .equal   (equal_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge: start of the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs_ee();
    return int'({busy_ee, done_ee, less_ee, greater_ee, equal_ee});
  endfunction

  // Issue a request in the current cycle (cycle 0), scramble operands afterwards,
  // and return the done cycle (-1 if none within budget), busy count, and the
  // {less,greater,equal} seen in cycle 1. Returns while sitting in the done cycle.
  task automatic run(input bit fx, input logic [7:0] av, input logic [7:0] bv,
                     output int dcyc, output int bcnt, output int res1);
    logic bz, dn;
    dcyc = -1;
    bcnt = 0;
    res1 = 0;
    if (fx) begin
      start_fx = 1'b1; a_fx = av; b_fx = bv;
    end else begin
      start_ee = 1'b1; a_ee = av; b_ee = bv;
    end
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      tick();
      start_ee = 1'b0;
      start_fx = 1'b0;
      if (fx) begin a_fx = ~av; b_fx = ~bv; end
      else    begin a_ee = ~av; b_ee = ~bv; end
      bz = fx ? busy_fx : busy_ee;
      dn = fx ? done_fx : done_ee;
      if (bz) bcnt++;
      if (c == 1)
        res1 = fx ? int'({less_fx, greater_fx, equal_fx})
                  : int'({less_ee, greater_ee, equal_ee});
      if (dn) dcyc = c;
    end
  endtask

  int dcyc, bcnt, res1, dseen;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start_ee = 1'b0; a_ee = 8'h00; b_ee = 8'h00;
    start_fx = 1'b0; a_fx = 8'h00; b_fx = 8'h00;

    // Reset held for two cycles, then idle with start low.
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outs_ee", outs_ee(), 0);
    chk("reset_outs_fx", int'({busy_fx, done_fx, less_fx, greater_fx, equal_fx}), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", outs_ee(), 0);
    end

    // Early exit at bit 7: done in cycle 2, busy for cycle 1 only.
    run(1'b0, 8'hA5, 8'h25, dcyc, bcnt, res1);
    chk("ee_a5_25_done_cyc", dcyc, 2);
    chk("ee_a5_25_busy_cnt", bcnt, 1);
    chk("ee_a5_25_res", int'({less_ee, greater_ee, equal_ee}), 3'b010);
    chk("ee_a5_25_busy_in_done", int'(busy_ee), 0);

    // Results hold after done until the next done.
    tick(); tick(); tick();
    chk("hold_outs", outs_ee(), 5'b00010);

    // Equal operands scan all bits.
    run(1'b0, 8'h3C, 8'h3C, dcyc, bcnt, res1);
    chk("ee_eq_done_cyc", dcyc, 9);
    chk("ee_eq_busy_cnt", bcnt, 8);
    chk("ee_eq_res", int'({less_ee, greater_ee, equal_ee}), 3'b001);
    tick();

    // Difference only at bit 0.
    run(1'b0, 8'h10, 8'h11, dcyc, bcnt, res1);
    chk("ee_bit0_done_cyc", dcyc, 9);
    chk("ee_bit0_res", int'({less_ee, greater_ee, equal_ee}), 3'b100);
    tick();

    // Fixed latency: MSB decides, lower bits favouring B must not flip it.
    run(1'b1, 8'h80, 8'h7F, dcyc, bcnt, res1);
    chk("fx_80_7f_done_cyc", dcyc, 9);
    chk("fx_80_7f_busy_cnt", bcnt, 8);
    chk("fx_80_7f_res", int'({less_fx, greater_fx, equal_fx}), 3'b010);
    tick();
    chk("fx_done_pulse_one_cycle", int'(done_fx), 0);
    run(1'b0, 8'h80, 8'h7F, dcyc, bcnt, res1);
    chk("ee_80_7f_done_cyc", dcyc, 2);
    tick();

    // Busy protection: a second start mid-scan with a new operand is ignored.
    dcyc = -1;
    start_ee = 1'b1; a_ee = 8'h01; b_ee = 8'h02;
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      tick();
      start_ee = (c == 3);
      a_ee = (c == 3) ? 8'hFF : 8'h01;
      if (done_ee) dcyc = c;
    end
    chk("busy_prot_done_cyc", dcyc, 8);
    chk("busy_prot_res", int'({less_ee, greater_ee, equal_ee}), 3'b100);

    // Start in the done cycle is accepted; old result held until the new done.
    run(1'b0, 8'h05, 8'h05, dcyc, bcnt, res1);
    chk("b2b_busy_cnt", bcnt, 8);
    chk("b2b_res_not_cleared", res1, 3'b100);
    chk("b2b_done_cyc", dcyc, 9);
    chk("b2b_res", int'({less_ee, greater_ee, equal_ee}), 3'b001);
    tick();

    // Reset in cycle 4 of a scan: everything clears, no done pulse.
    start_ee = 1'b1; a_ee = 8'h00; b_ee = 8'h00;
    tick(); start_ee = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midscan_rst_outs", outs_ee(), 0);
    dseen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_ee) dseen++;
    end
    chk("midscan_rst_no_done", dseen, 0);
    chk("midscan_rst_idle_outs", outs_ee(), 0);

    // Fresh compare after the abort.
    run(1'b0, 8'h40, 8'h80, dcyc, bcnt, res1);
    chk("post_rst_done_cyc", dcyc, 2);
    chk("post_rst_res", int'({less_ee, greater_ee, equal_ee}), 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
